// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer: one-hot FSM state encoding.
package piso_pkg;

    // One-hot serializer states; S_PARITY is only entered when PISO_PARITY_EN is defined.
    typedef enum logic [3:0] {
        S_FIFO_EMPTY        = 4'b0001,
        S_RD_FIFO           = 4'b0010,
        S_DRIVE_SERIAL_INTF = 4'b0100,
        S_PARITY            = 4'b1000
    } piso_state_t;

endpackage

// File: rtl/piso_sync_fifo.sv
// Single-clock word FIFO feeding the serializer. The head word is visible
// combinationally so the shifter can load it on the same edge as the pop.
module piso_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_reg == LVL_W'(DEPTH));
    assign empty     = (count_reg == '0);
    assign do_push   = push && !full && !flush;
    assign do_pop    = pop && !empty && !flush;
    assign head_data = mem[rd_ptr_reg];
    assign level     = count_reg;

    // Storage array; no reset so it maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; flush empties the queue.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + LVL_W'(1);
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/piso_ser_fifo.sv
// Parallel-in/serial-out serializer with input FIFO. Words enter on a
// valid/ready handshake, bits leave on a bit-level valid/ready handshake.
// Optional even-parity trailer bit: define PISO_PARITY_EN.
module piso_ser_fifo
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic                   data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   last_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int LVL_W     = $clog2(DEPTH) + 1;
    localparam int CNT_W     = $clog2(WIDTH + 1);
    localparam int FIRST_IDX = (MSB_FIRST != 0) ? WIDTH - 1 : 0;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    piso_state_t      state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] bit_cnt_reg;
    logic             valid_reg;
    logic             data_reg;
    logic             last_reg;
    logic             ready_reg;
`ifdef PISO_PARITY_EN
    logic             parity_reg;
`endif

    logic [WIDTH-1:0] head_data;
    logic [LVL_W-1:0] fifo_level;
    logic [LVL_W-1:0] level_next;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             bit_accept;
    logic             word_done;

    assign bit_accept = valid_reg && ready_i;
    // last_reg marks the final bit of the word (data bit or parity bit).
    assign word_done  = bit_accept && last_reg;
    assign push       = valid_i && ready_reg && !fifo_full && !flush_i;
    // A pop always coincides with a shifter load: from S_RD_FIFO, or back-to-back after a last bit.
    assign pop        = !flush_i && ((state_reg == S_RD_FIFO) || (word_done && !fifo_empty));

    assign ready_o = ready_reg;
    assign data_o  = data_reg;
    assign valid_o = valid_reg;
    assign last_o  = last_reg;
    assign level_o = fifo_level;

    piso_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush     (flush_i),
        .push      (push),
        .pop       (pop),
        .wr_data   (data_i),
        .head_data (head_data),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next FIFO occupancy, used to register ready_o one cycle ahead.
    always_comb begin
        level_next = fifo_level;
        if (flush_i) begin
            level_next = '0;
        end else if (push && !pop) begin
            level_next = fifo_level + LVL_W'(1);
        end else if (pop && !push) begin
            level_next = fifo_level - LVL_W'(1);
        end
    end

    // Remaining bits after one shift, oriented so the next bit lands at FIRST_IDX.
    always_comb begin
        shifted = '0;
        if (MSB_FIRST != 0) begin
            shifted = shift_reg << 1;
        end else begin
            shifted = shift_reg >> 1;
        end
    end

    // ready_o is low for the whole cycle the FIFO holds DEPTH words.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_reg <= 1'b0;
        end else begin
            ready_reg <= (level_next != LVL_W'(DEPTH));
        end
    end

    // Serializer FSM with shifter, bit counter and registered serial outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= S_FIFO_EMPTY;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            valid_reg   <= 1'b0;
            data_reg    <= 1'b0;
            last_reg    <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else if (flush_i) begin
            state_reg   <= S_FIFO_EMPTY;
            bit_cnt_reg <= '0;
            valid_reg   <= 1'b0;
            data_reg    <= 1'b0;
            last_reg    <= 1'b0;
        end else if (pop) begin
            state_reg   <= S_DRIVE_SERIAL_INTF;
            shift_reg   <= head_data;
            data_reg    <= head_data[FIRST_IDX];
            bit_cnt_reg <= '0;
            valid_reg   <= 1'b1;
            last_reg    <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_reg  <= ^head_data;
`endif
        end else begin
            case (state_reg)
                S_FIFO_EMPTY: begin
                    if (fifo_level != '0) begin
                        state_reg <= S_RD_FIFO;
                    end
                end
                S_RD_FIFO: begin
                    // Always left through the pop branch above.
                    state_reg <= S_RD_FIFO;
                end
                S_DRIVE_SERIAL_INTF: begin
                    if (bit_accept) begin
                        if (bit_cnt_reg == LAST_IDX) begin
`ifdef PISO_PARITY_EN
                            state_reg   <= S_PARITY;
                            data_reg    <= parity_reg;
                            last_reg    <= 1'b1;
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
`else
                            state_reg <= S_FIFO_EMPTY;
                            valid_reg <= 1'b0;
                            last_reg  <= 1'b0;
`endif
                        end else begin
                            shift_reg   <= shifted;
                            data_reg    <= shifted[FIRST_IDX];
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
`ifdef PISO_PARITY_EN
                            last_reg    <= 1'b0;
`else
                            last_reg    <= ((bit_cnt_reg + CNT_W'(1)) == LAST_IDX);
`endif
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_accept) begin
                        state_reg <= S_FIFO_EMPTY;
                        valid_reg <= 1'b0;
                        last_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= S_FIFO_EMPTY;
                    valid_reg <= 1'b0;
                    last_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/piso_ser_fifo.md
# piso_ser_fifo

Parametrised single-clock parallel-in/serial-out serializer with an integrated input FIFO, for the SerDes transmit path. Parallel words are accepted on a valid/ready handshake, buffered, and shifted out one bit per accepted transfer on a bit-level valid/ready handshake, with a last-bit marker. It is the successor to the fixed 8-bit, two-clock PISO: the serial rate is set by downstream `ready_i` instead of a second clock.

## Interface
- `WIDTH`, 8: parallel word width, ≥2.
- `DEPTH`, 4: FIFO depth in words, power of 2, ≥2.
- `MSB_FIRST`, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `flush_i`  in  1  synchronous clear of FIFO and the word in flight.
- `data_i`  in  WIDTH  parallel word.
- `valid_i`  in  1  `data_i` valid.
- `ready_o`  out  1  the FIFO can accept a word. Registered.
- `data_o`  out  1  serial bit.
- `valid_o`  out  1  `data_o` valid.
- `ready_i`  in  1  downstream accepts the bit.
- `last_o`  out  1  the current bit is the last of its word.
- `level_o`  out  $clog2(DEPTH)+1  number of words in the FIFO, excluding the word in the shifter.

## Operation
- Write: occurs when `valid_i && ready_o` at a rising edge. `ready_o` is the registered value of (next level != DEPTH). It is low during a full cycle even if a pop happens in the same cycle; there is no pass-through.
- FSM, one-hot:
  - S_FIFO_EMPTY: `valid_o` = 0. If `level_o` != 0, go to S_RD_FIFO.
  - S_RD_FIFO: pop the head word into the shifter, clear the bit counter, go to S_DRIVE_SERIAL_INTF. `valid_o` = 0.
  - S_DRIVE_SERIAL_INTF: `valid_o` = 1. The bit advances only on `valid_o && ready_i`.
    - On an accepted last bit with the FIFO non-empty, pop the next word directly and stay in this state. There is no gap between words.
    - On an accepted last bit with the FIFO empty, go to S_FIFO_EMPTY.
  - S_PARITY: present only with the macro (see Configuration).
- While `ready_i` = 0: `data_o`, `last_o` and the bit counter hold. `valid_o` is never withdrawn except by `flush_i` or `rst_i`.
- Bit counter is $clog2(WIDTH+1) bits wide. `last_o` = 1 on bit index WIDTH-1 (on the parity bit when the macro is defined).
- Simultaneous write and pop: `level_o` is unchanged.
- `flush_i`:
  - Has priority over a write in the same cycle; that write is dropped.
  - The next cycle shows `level_o` = 0, state S_FIFO_EMPTY, `valid_o` = 0 and `last_o` = 0.
  - The word in flight is abandoned mid-word.
- Reset mid-word: same end state as flush, applied immediately; `ready_o` = 0.

## Timing
- Reset values:
  - `ready_o`, `valid_o`, `data_o`, `last_o` = 0; `level_o` = 0; state S_FIFO_EMPTY.
  - `ready_o` goes high after the first clock edge following reset release.
- Latency from idle: a word written at edge N is popped at edge N+1 (S_RD_FIFO). Its first bit is valid after edge N+2.
- Throughput with `ready_i` held at 1: one bit per clock, continuous across words. A word takes WIDTH cycles, or WIDTH+1 with parity.
- Accepted-word capacity: DEPTH in the FIFO plus 1 in the shifter.

## Configuration
- `PISO_PARITY_EN` defined:
  - After the last data bit, state S_PARITY drives one extra bit equal to `^word` (even parity).
  - `last_o` = 1 on the parity bit only.
  - The exit rules are those of the data bits.
- Undefined: words are WIDTH bits, S_PARITY is unreachable, and `last_o` marks data bit WIDTH-1.

## Structure
- `piso_pkg`: one-hot state localparams S_FIFO_EMPTY = 4'b0001, S_RD_FIFO = 4'b0010, S_DRIVE_SERIAL_INTF = 4'b0100, S_PARITY = 4'b1000, plus a state typedef.
- Sub-module `piso_sync_fifo`, WIDTH × DEPTH:
  - Inputs: push, pop, flush.
  - Outputs: head data, level, full, empty.
  - Pointers wrap modulo DEPTH.
- Top level: FSM, shifter, bit counter, `ready_o` register.

## Test plan
- WIDTH=8, MSB_FIRST=1, `ready_i`=1: write 8'hA5 → `data_o` = 1,0,1,0,0,1,0,1 on consecutive cycles starting 2 clk after the write; `last_o` high on the 8th bit only.
- Back-to-back: write 8'hFF then 8'h00 → 16 contiguous `valid_o` cycles, eight 1s then eight 0s, no bubble.
- Backpressure: drop `ready_i` for 3 cycles after bit 3 of 8'h3C → `data_o` and `last_o` stable, remaining bits resume in order, no bit lost or duplicated.
- Full/wrap, DEPTH=4, `ready_i`=0: offer 6 words → 5 accepted, `ready_o` low, `level_o`=4. Release `ready_i` → all 5 words emerge in order; FIFO pointers wrap; `ready_o` returns high after the first pop.
- Flush and reset mid-word: assert `flush_i` at bit 4 with 2 words queued → next cycle `valid_o`=0, `level_o`=0. Repeat with `rst_i` → all outputs 0 immediately.
- MSB_FIRST=0, 8'h01 → first bit 1, then seven 0s. With `PISO_PARITY_EN`, 8'h07 → 9th bit = 1 with `last_o`=1.
